l1_cache: RTL and testbench

//  Direct-mapped, write-through, write-allocate L1 data cache. It sits between the CPU load/store port
//  and L2_cache. It serves single-word CPU reads and writes from a local block store. On a miss it

---
 rtl/cache_pkg.sv | 23 ++
 rtl/l1_line_store.sv | 60 ++++++
 rtl/l1_cache.sv | 171 +++++++++++++++++
 tb/tb_l1_cache.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared cache definitions: controller state encoding and derived address-field widths.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOOKUP     = 2'd1,
        FETCH      = 2'd2,
        WRITE_THRU = 2'd3
    } cache_state_e;

    function automatic int calc_off_w(input int block_size);
        return $clog2(block_size);
    endfunction

    function automatic int calc_idx_w(input int cache_size, input int block_size);
        return $clog2(cache_size / block_size);
    endfunction

    function automatic int calc_tag_w(input int addr_width, input int cache_size, input int block_size);
        return addr_width - calc_idx_w(cache_size, block_size) - calc_off_w(block_size);
    endfunction

endpackage

// File: rtl/l1_line_store.sv
// Tag/valid/data arrays for the L1 cache: one combinational read port, one write port
// that can replace a single word of the incoming block before storing it.
module l1_line_store #(
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 32,
    parameter int LINES      = 4,
    parameter int TAG_W      = 4,
    parameter int IDX_W      = 2,
    parameter int OFF_W      = 5
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [IDX_W-1:0]                 i_rd_idx,
    output logic                             o_rd_valid,
    output logic [TAG_W-1:0]                 o_rd_tag,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] o_rd_block,
    input  logic                             i_we,
    input  logic [IDX_W-1:0]                 i_wr_idx,
    input  logic [TAG_W-1:0]                 i_wr_tag,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] i_wr_block,
    input  logic                             i_merge,
    input  logic [OFF_W-1:0]                 i_merge_off,
    input  logic [DATA_WIDTH-1:0]            i_merge_word,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] o_merged_block
);

    logic [LINES-1:0]                 r_valid;
    logic [TAG_W-1:0]                 r_tag  [LINES];
    logic [BLOCK_SIZE*DATA_WIDTH-1:0] r_data [LINES];

    // NOTE: every combinational output gets a full default before any conditional update, so no latch is inferred.
    always_comb begin
        o_merged_block = i_wr_block;
        if (i_merge) begin
            o_merged_block[i_merge_off*DATA_WIDTH +: DATA_WIDTH] = i_merge_word;
        end
    end

    assign o_rd_valid = r_valid[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_block = r_data[i_rd_idx];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // NOTE: tag and data arrays are deliberately not reset; a cleared valid bit makes their contents irrelevant.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= o_merged_block;
        end
    end

endmodule

// File: rtl/l1_cache.sv
// Direct-mapped, write-through, write-allocate L1 data cache between the CPU port and L2.
// Misses fetch a whole block; every store is forwarded to L2 as the full merged block.
module l1_cache
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 11,
    parameter int CACHE_SIZE = 128,
    parameter int BLOCK_SIZE = 32
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_WIDTH-1:0]            cpu_addr,
    input  logic [DATA_WIDTH-1:0]            cpu_wdata,
    input  logic                             cpu_read,
    input  logic                             cpu_write,
    output logic [DATA_WIDTH-1:0]            cpu_rdata,
    output logic                             cpu_ready,
    output logic                             cpu_hit,
    output logic [ADDR_WIDTH-1:0]            l2_addr,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_data_out,
    output logic                             l2_read,
    output logic                             l2_write,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] l2_block_data_in,
    input  logic                             l2_block_valid,
    input  logic                             l2_ready,
    input  logic                             l2_hit
);

    localparam int LINES = CACHE_SIZE / BLOCK_SIZE;
    localparam int OFF_W = calc_off_w(BLOCK_SIZE);
    localparam int IDX_W = calc_idx_w(CACHE_SIZE, BLOCK_SIZE);
    localparam int TAG_W = calc_tag_w(ADDR_WIDTH, CACHE_SIZE, BLOCK_SIZE);
    localparam int BLK_W = BLOCK_SIZE * DATA_WIDTH;

    cache_state_e            r_state;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic                    r_is_write;
    logic                    r_hit;
    logic [DATA_WIDTH-1:0]   r_cpu_rdata;
    logic                    r_cpu_ready;
    logic                    r_cpu_hit;
    logic [ADDR_WIDTH-1:0]   r_l2_addr;
    logic [BLK_W-1:0]        r_l2_data;

    logic [TAG_W-1:0]        w_tag;
    logic [IDX_W-1:0]        w_idx;
    logic [OFF_W-1:0]        w_off;
    logic                    w_rd_valid;
    logic [TAG_W-1:0]        w_rd_tag;
    logic [BLK_W-1:0]        w_rd_block;
    logic                    w_lookup_hit;
    logic                    w_fill;
    logic                    w_we;
    logic [BLK_W-1:0]        w_src_block;
    logic [DATA_WIDTH-1:0]   w_src_word;
    logic [BLK_W-1:0]        w_merged;
    logic                    w_unused_l2_hit;

    assign w_tag = r_addr[ADDR_WIDTH-1 -: TAG_W];
    assign w_idx = r_addr[OFF_W +: IDX_W];
    assign w_off = r_addr[OFF_W-1:0];

    assign w_lookup_hit = w_rd_valid && (w_rd_tag == w_tag);
    assign w_fill       = (r_state == FETCH) && l2_ready && l2_block_valid;
    assign w_we         = w_fill || ((r_state == LOOKUP) && r_is_write && w_lookup_hit);
    // During FETCH the block comes from L2; during LOOKUP it is the resident line.
    assign w_src_block  = (r_state == FETCH) ? l2_block_data_in : w_rd_block;
    assign w_src_word   = w_src_block[w_off*DATA_WIDTH +: DATA_WIDTH];

    assign w_unused_l2_hit = l2_hit;

    l1_line_store #(
        .DATA_WIDTH (DATA_WIDTH),
        .BLOCK_SIZE (BLOCK_SIZE),
        .LINES      (LINES),
        .TAG_W      (TAG_W),
        .IDX_W      (IDX_W),
        .OFF_W      (OFF_W)
    ) u_line_store (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_rd_idx       (w_idx),
        .o_rd_valid     (w_rd_valid),
        .o_rd_tag       (w_rd_tag),
        .o_rd_block     (w_rd_block),
        .i_we           (w_we),
        .i_wr_idx       (w_idx),
        .i_wr_tag       (w_tag),
        .i_wr_block     (w_src_block),
        .i_merge        (r_is_write),
        .i_merge_off    (w_off),
        .i_merge_word   (r_wdata),
        .o_merged_block (w_merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_is_write  <= 1'b0;
            r_hit       <= 1'b0;
            r_cpu_rdata <= '0;
            r_cpu_ready <= 1'b0;
            r_cpu_hit   <= 1'b0;
            r_l2_addr   <= '0;
            r_l2_data   <= '0;
        end else begin
            r_cpu_ready <= 1'b0;
            r_cpu_hit   <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    // The response-cycle check keeps a still-held request from being taken twice.
                    if ((cpu_read || cpu_write) && !r_cpu_ready) begin
                        r_addr     <= cpu_addr;
                        r_wdata    <= cpu_wdata;
                        r_is_write <= cpu_write;
                        r_state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    r_hit     <= w_lookup_hit;
                    r_l2_addr <= {w_tag, w_idx, {OFF_W{1'b0}}};
                    if (!w_lookup_hit) begin
                        r_state <= FETCH;
                    end else if (r_is_write) begin
                        r_l2_data <= w_merged;
                        r_state   <= WRITE_THRU;
                    end else begin
                        r_cpu_rdata <= w_src_word;
                        r_cpu_ready <= 1'b1;
                        r_cpu_hit   <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                FETCH: begin
                    if (w_fill) begin
                        if (r_is_write) begin
                            r_l2_data <= w_merged;
                            r_state   <= WRITE_THRU;
                        end else begin
                            r_cpu_rdata <= w_src_word;
                            r_cpu_ready <= 1'b1;
                            r_state     <= IDLE;
                        end
                    end
                end
                WRITE_THRU: begin
                    if (l2_ready) begin
                        r_cpu_ready <= 1'b1;
                        r_cpu_hit   <= r_hit;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Requests drop in the same cycle as l2_ready so L2 never re-samples them.
    assign l2_read     = (r_state == FETCH) && !l2_ready;
    assign l2_write    = (r_state == WRITE_THRU) && !l2_ready;
    assign l2_addr     = r_l2_addr;
    assign l2_data_out = r_l2_data;
    assign cpu_rdata   = r_cpu_rdata;
    assign cpu_ready   = r_cpu_ready;
    assign cpu_hit     = r_cpu_hit;

endmodule

// File: tb/tb_l1_cache.sv
// Self-checking bench for l1_cache: an L2 responder with its own memory, a transaction-level
// cache model, a per-cycle compare process and directed scenarios with literal expectations.
module tb_l1_cache;

    localparam int DW    = 32;
    localparam int AW    = 11;
    localparam int BS    = 32;
    localparam int BLK_W = BS * DW;
    localparam int L2_LAT = 3;

    logic             clk;
    logic             rst_n;
    logic [AW-1:0]    cpu_addr;
    logic [DW-1:0]    cpu_wdata;
    logic             cpu_read;
    logic             cpu_write;
    logic [DW-1:0]    cpu_rdata;
    logic             cpu_ready;
    logic             cpu_hit;
    logic [AW-1:0]    l2_addr;
    logic [BLK_W-1:0] l2_data_out;
    logic             l2_read;
    logic             l2_write;
    logic [BLK_W-1:0] l2_block_data_in;
    logic             l2_block_valid;
    logic             l2_ready;
    logic             l2_hit;

    l1_cache dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cpu_addr         (cpu_addr),
        .cpu_wdata        (cpu_wdata),
        .cpu_read         (cpu_read),
        .cpu_write        (cpu_write),
        .cpu_rdata        (cpu_rdata),
        .cpu_ready        (cpu_ready),
        .cpu_hit          (cpu_hit),
        .l2_addr          (l2_addr),
        .l2_data_out      (l2_data_out),
        .l2_read          (l2_read),
        .l2_write         (l2_write),
        .l2_block_data_in (l2_block_data_in),
        .l2_block_valid   (l2_block_valid),
        .l2_ready         (l2_ready),
        .l2_hit           (l2_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // L2 contents as seen by the responder, and the reference contents the model expects.
    logic [DW-1:0] l2_mem  [0:2047];
    logic [DW-1:0] ref_mem [0:2047];

    // Transaction-level model of the cache: which block each line holds.
    bit            c_valid [4];
    int            c_tag   [4];
    bit            exp_pending;
    bit            exp_is_write;
    bit            exp_hit;
    logic [DW-1:0] exp_rdata;
    logic [AW-1:0] exp_blk_addr;
    logic [BLK_W-1:0] exp_block;

    int            rd_starts = 0;
    int            wr_starts = 0;
    logic [AW-1:0] last_rd_addr;
    logic [AW-1:0] last_wr_addr;
    bit            prev_rd;
    bit            prev_wr;
    bit            nack_next;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_blk(input string name, input logic [BLK_W-1:0] act, input logic [BLK_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            for (int w = 0; w < BS; w++) begin
                if (act[w*DW +: DW] !== exp[w*DW +: DW]) begin
                    $display("FAIL %s: word %0d got 0x%0h expected 0x%0h", name, w,
                             act[w*DW +: DW], exp[w*DW +: DW]);
                    break;
                end
            end
        end
    endtask

    function automatic logic [BLK_W-1:0] ref_block(input int base);
        logic [BLK_W-1:0] b;
        for (int w = 0; w < BS; w++) b[w*DW +: DW] = ref_mem[base + w];
        return b;
    endfunction

    // L2 responder: answers after L2_LAT cycles with a one-cycle l2_ready pulse.
    initial begin : l2_responder
        int wait_cnt;
        wait_cnt         = 0;
        l2_ready         = 1'b0;
        l2_block_valid   = 1'b0;
        l2_block_data_in = '0;
        l2_hit           = 1'b0;
        forever begin
            @(negedge clk);
            if (l2_ready) begin
                @(posedge clk); #1;
                l2_ready       = 1'b0;
                l2_block_valid = 1'b0;
                l2_hit         = 1'b0;
            end else if (rst_n && (l2_read || l2_write)) begin
                wait_cnt++;
                if (wait_cnt >= L2_LAT) begin
                    wait_cnt = 0;
                    @(posedge clk); #1;
                    if (l2_read) begin
                        for (int w = 0; w < BS; w++) l2_block_data_in[w*DW +: DW] = l2_mem[int'(l2_addr) + w];
                        l2_block_valid = !nack_next;
                        nack_next      = 1'b0;
                    end else begin
                        for (int w = 0; w < BS; w++) l2_mem[int'(l2_addr) + w] = l2_data_out[w*DW +: DW];
                    end
                    l2_hit   = 1'b1;
                    l2_ready = 1'b1;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (l2_read && !prev_rd) begin
                rd_starts++;
                last_rd_addr = l2_addr;
            end
            if (l2_write && !prev_wr) begin
                wr_starts++;
                last_wr_addr = l2_addr;
            end
            prev_rd = l2_read;
            prev_wr = l2_write;
            if (l2_read || l2_write) check("l2_addr", 64'(l2_addr), 64'(exp_blk_addr));
            if (l2_read) check("l2_read_only_on_miss", 64'(exp_pending && !exp_hit), 64'd1);
            if (l2_write) begin
                check("l2_write_only_on_store", 64'(exp_pending && exp_is_write), 64'd1);
                check_blk("l2_data_out", l2_data_out, exp_block);
            end
            if (cpu_ready) begin
                check("cpu_ready_only_when_pending", 64'(exp_pending), 64'd1);
                check("cpu_hit", 64'(cpu_hit), 64'(exp_hit));
                if (!exp_is_write) check("cpu_rdata", 64'(cpu_rdata), 64'(exp_rdata));
                exp_pending = 1'b0;
            end else begin
                check("cpu_hit_without_ready", 64'(cpu_hit), 64'd0);
            end
        end else begin
            prev_rd = 1'b0;
            prev_wr = 1'b0;
        end
    end

    task automatic do_op(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         output logic [DW-1:0] rd, output logic hit, output int lat);
        int  idx;
        int  tg;
        bit  got;
        idx = int'(a[6:5]);
        tg  = int'(a[10:7]);
        exp_hit = c_valid[idx] && (c_tag[idx] == tg);
        if (wr) ref_mem[a] = d;
        exp_rdata    = ref_mem[a];
        exp_is_write = wr;
        exp_blk_addr = {a[10:5], 5'd0};
        exp_block    = ref_block(int'({a[10:5], 5'd0}));
        c_valid[idx] = 1'b1;
        c_tag[idx]   = tg;
        exp_pending  = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_read  = !wr;
        cpu_write = wr;
        lat = 0;
        got = 1'b0;
        rd  = '0;
        hit = 1'b0;
        while (!got && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (cpu_ready) begin
                got = 1'b1;
                rd  = cpu_rdata;
                hit = cpu_hit;
            end
        end
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        check("response_within_budget", 64'(got), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cpu_rdata"},   64'(cpu_rdata), 64'd0);
        check({tag, "_cpu_ready"},   64'(cpu_ready), 64'd0);
        check({tag, "_cpu_hit"},     64'(cpu_hit),   64'd0);
        check({tag, "_l2_addr"},     64'(l2_addr),   64'd0);
        check({tag, "_l2_read"},     64'(l2_read),   64'd0);
        check({tag, "_l2_write"},    64'(l2_write),  64'd0);
        check({tag, "_l2_data_out"}, 64'(l2_data_out == '0), 64'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [DW-1:0] rd;
        logic          hit;
        int            lat;
        int            rd0;
        int            wr0;
        bit            seen;

        for (int a = 0; a < 2048; a++) begin
            l2_mem[a]  = DW'(a + 'hC0);
            ref_mem[a] = DW'(a + 'hC0);
        end
        for (int i = 0; i < 4; i++) begin
            c_valid[i] = 1'b0;
            c_tag[i]   = 0;
        end
        exp_pending = 1'b0;
        nack_next   = 1'b0;
        rst_n     = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1. Cold read of 0x045.
        rd0 = rd_starts;
        do_op(1'b0, 11'h045, '0, rd, hit, lat);
        check("t1_rdata", 64'(rd), 64'h105);
        check("t1_hit", 64'(hit), 64'd0);
        check("t1_l2_reads", 64'(rd_starts - rd0), 64'd1);
        check("t1_l2_addr", 64'(last_rd_addr), 64'h040);

        // 2. Read hit of the top word of the same block.
        rd0 = rd_starts;
        do_op(1'b0, 11'h05F, '0, rd, hit, lat);
        check("t2_rdata", 64'(rd), 64'h11F);
        check("t2_hit", 64'(hit), 64'd1);
        check("t2_latency", 64'(lat), 64'd2);
        check("t2_no_l2_read", 64'(rd_starts - rd0), 64'd0);

        // 3. Write hit, then read it back.
        wr0 = wr_starts;
        rd0 = rd_starts;
        do_op(1'b1, 11'h047, 32'hDEADBEEF, rd, hit, lat);
        check("t3_hit", 64'(hit), 64'd1);
        check("t3_l2_writes", 64'(wr_starts - wr0), 64'd1);
        check("t3_wr_addr", 64'(last_wr_addr), 64'h040);
        check("t3_l2_word7", 64'(l2_mem[11'h047]), 64'hDEADBEEF);
        check("t3_l2_word6", 64'(l2_mem[11'h046]), 64'h106);
        do_op(1'b0, 11'h047, '0, rd, hit, lat);
        check("t3_readback", 64'(rd), 64'hDEADBEEF);
        check("t3_readback_hit", 64'(hit), 64'd1);
        check("t3_no_l2_read", 64'(rd_starts - rd0), 64'd0);

        // 4. Write miss with one refused fetch (l2_ready without l2_block_valid).
        wr0 = wr_starts;
        rd0 = rd_starts;
        nack_next = 1'b1;
        do_op(1'b1, 11'h1C3, 32'h12345678, rd, hit, lat);
        check("t4_hit", 64'(hit), 64'd0);
        check("t4_l2_reads_with_retry", 64'(rd_starts - rd0), 64'd2);
        check("t4_rd_addr", 64'(last_rd_addr), 64'h1C0);
        check("t4_l2_writes", 64'(wr_starts - wr0), 64'd1);
        check("t4_wr_addr", 64'(last_wr_addr), 64'h1C0);
        check("t4_l2_word3", 64'(l2_mem[11'h1C3]), 64'h12345678);
        check("t4_l2_word2", 64'(l2_mem[11'h1C2]), 64'h282);

        // 5. Same index, different tag: each read evicts the other.
        rd0 = rd_starts;
        do_op(1'b0, 11'h040, '0, rd, hit, lat);
        check("t5_first_rdata", 64'(rd), 64'h100);
        do_op(1'b0, 11'h440, '0, rd, hit, lat);
        check("t5_second_rdata", 64'(rd), 64'h500);
        check("t5_second_hit", 64'(hit), 64'd0);
        do_op(1'b0, 11'h040, '0, rd, hit, lat);
        check("t5_third_hit", 64'(hit), 64'd0);
        check("t5_l2_reads", 64'(rd_starts - rd0), 64'd3);

        // 6. Reset in the middle of FETCH.
        cpu_addr = 11'h300;
        cpu_read = 1'b1;
        exp_hit      = 1'b0;
        exp_is_write = 1'b0;
        exp_blk_addr = 11'h300;
        exp_pending  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = l2_read;
        end
        check("t6_fetch_started", 64'(seen), 64'd1);
        rst_n    = 1'b0;
        cpu_read = 1'b0;
        #1;
        check_all_zero("t6_reset");
        for (int i = 0; i < 4; i++) c_valid[i] = 1'b0;
        exp_pending = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd0 = rd_starts;
        do_op(1'b0, 11'h045, '0, rd, hit, lat);
        check("t6_after_reset_hit", 64'(hit), 64'd0);
        check("t6_after_reset_rdata", 64'(rd), 64'h105);
        check("t6_after_reset_l2_reads", 64'(rd_starts - rd0), 64'd1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
